// File: rtl/busarb_pkg.sv
// busarb_pkg: shared state encoding, grant polarity and owner-width helper for the round-robin bus arbiter
package busarb_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t GRANT   = 2'd1;
    localparam state_t RELEASE = 2'd2;
    localparam state_t DMA     = 2'd3;
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;
    function automatic int owner_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/busarb_rr_pick.sv
// rr_pick: rotating-priority search, first set req bit at or after ptr (modulo NMASTER)
module rr_pick import busarb_pkg::*; #(
    parameter int NMASTER = 4,
    localparam int W = owner_w(NMASTER)
) (
    input  logic [NMASTER-1:0] req,
    input  logic [W-1:0]       ptr,
    output logic [W-1:0]       idx,
    output logic               valid
);
    logic [W-1:0] j;
    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        idx = '0;
        j = '0;
        for (int i = NMASTER - 1; i >= 0; i--) begin
            j = W'((int'(ptr) + i) % NMASTER);
            if (req[j]) idx = j;
        end
    end
    assign valid = |req;
endmodule

// File: rtl/busarb_rr.sv
// busarb_rr: round-robin bus arbiter with tenure timeout, one-cycle release turnaround and DMA fallback
module busarb_rr import busarb_pkg::*; #(
    parameter int NMASTER = 4,
    parameter int TIMEOUT = 255,
    parameter int TOWIDTH = 16,
    localparam int W = owner_w(NMASTER)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NMASTER-1:0] breq_,
    input  logic [NMASTER-1:0] done,
    input  logic               dmareq,
    output logic [NMASTER-1:0] bgrt_,
    output logic               free_,
    output logic [W-1:0]       owner,
    output logic               timeout
);
    state_t state;
    logic [W-1:0] rr_ptr, pick_idx, ptr_nxt;
    logic [TOWIDTH-1:0] cnt;
    logic pick_valid, to_hit, rel;
    rr_pick #(.NMASTER(NMASTER)) u_pick (
        .req(~breq_), .ptr(rr_ptr), .idx(pick_idx), .valid(pick_valid)
    );
    assign to_hit  = cnt == TOWIDTH'(TIMEOUT);
    assign rel     = done[owner] | breq_[owner] | to_hit;
    assign ptr_nxt = (pick_idx == W'(NMASTER - 1)) ? '0 : pick_idx + 1'b1;
    // RELEASE arbitrates like IDLE, so back-to-back grants are separated by exactly one turnaround cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bgrt_   <= {NMASTER{Disable_}};
            free_   <= Disable_;
            owner   <= '0;
            timeout <= 1'b0;
            rr_ptr  <= '0;
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, RELEASE:
                    if (pick_valid) begin
                        state  <= GRANT;
                        bgrt_  <= ~(NMASTER'(1) << pick_idx);
                        owner  <= pick_idx;
                        rr_ptr <= ptr_nxt;
                        cnt    <= '0;
                    end else if (dmareq) begin
                        state <= DMA;
                        free_ <= Enable_;
                    end else begin
                        state <= IDLE;
                    end
                GRANT:
                    if (rel) begin
                        state   <= RELEASE;
                        bgrt_   <= {NMASTER{Disable_}};
                        owner   <= '0;
                        timeout <= to_hit & ~done[owner];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                DMA:
                    if (!dmareq || !(&breq_)) begin
                        state <= RELEASE;
                        free_ <= Disable_;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
